// File: rtl/grp_buf_pkg.sv
// Shared types and helpers for the orbit group-buffer write arbiter.
package grp_buf_pkg;

    localparam int ORB_DATA_W = 12;
    localparam int ORB_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SWAP  = 2'd2
    } arb_state_e;

    // Index of the set bit of a one-hot vector (up to 16 channels); 0 if none.
    function automatic int unsigned onehot2idx(input logic [15:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational channel picker for the group-buffer arbiter.
// Default: round-robin starting after the last granted index.
// ARB_FIXED_PRIO_EN defined: strict priority, lowest index wins (last_i ignored).
module rr_pick
    import grp_buf_pkg::*;
#(
    parameter int CHANNELS = 5,
    localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IDX_W-1:0]    last_i,
    output logic [CHANNELS-1:0] pick_o
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_i;

    // Lowest requesting index wins.
    always_comb begin
        logic found;
        found  = 1'b0;
        pick_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && req_i[i]) begin
                pick_o[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`else
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk last+1, last+2, ... wrapping; the last granted channel is tried last.
    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            sum = {1'b0, last_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(CHANNELS)) sum = sum - (IDX_W+1)'(CHANNELS);
            cand = sum[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                pick_o[cand] = 1'b1;
                found        = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/grp_buf_arbiter.sv
// N-channel write arbiter for the orbit group ping-pong buffers.
// Grants one channel per burst, muxes its write/old-word-read ports onto the
// buffer, owns the bank select and defers swaps to burst boundaries.
// A per-grant watchdog forces release after HOLD_MAX cycles.
// Build option: ARB_FIXED_PRIO_EN selects strict priority instead of round-robin.
module grp_buf_arbiter
    import grp_buf_pkg::*;
#(
    parameter int CHANNELS = 5,
    parameter int DATA_W   = ORB_DATA_W,
    parameter int ADDR_W   = ORB_ADDR_W,
    parameter int HOLD_MAX = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        ch_busy,
    input  logic [CHANNELS*DATA_W-1:0] ch_wdata,
    input  logic [CHANNELS*ADDR_W-1:0] ch_waddr,
    input  logic [CHANNELS-1:0]        ch_wren,
    input  logic [CHANNELS*ADDR_W-1:0] ch_raddr,
    input  logic [CHANNELS-1:0]        ch_rden,
    output logic [CHANNELS-1:0]        ch_grant,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [DATA_W-1:0]          buf_wdata,
    output logic [ADDR_W-1:0]          buf_waddr,
    output logic                       buf_wren,
    output logic [ADDR_W-1:0]          buf_raddr,
    output logic                       buf_rden,
    input  logic [DATA_W-1:0]          buf_rdata,
    input  logic                       swap_req,
    output logic                       bank_sel,
    output logic                       swap_late,
    output logic [CHANNELS-1:0]        tmo_err
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int HC_W  = $clog2(HOLD_MAX);

    arb_state_e          state_q, state_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [HC_W-1:0]     hold_q, hold_d;
    logic                bank_q, bank_d;
    logic                pend_q, pend_d;
    logic                late_q, late_d;
    logic [CHANNELS-1:0] tmo_q, tmo_d;

    logic [CHANNELS-1:0] pick;
    logic                busy_g;
    logic                hold_max;

    rr_pick #(.CHANNELS(CHANNELS)) u_pick (
        .req_i  (ch_busy),
        .last_i (last_q),
        .pick_o (pick)
    );

    assign busy_g   = |(ch_busy & grant_q);
    assign hold_max = (hold_q == HC_W'(HOLD_MAX - 1));

    // A swap request is remembered until the SWAP cycle; a second request while
    // one is still waiting only raises the sticky late flag.
    assign pend_d = (state_q == SWAP) ? 1'b0 : (pend_q | swap_req);
    assign late_d = late_q | (swap_req & pend_q);

    // Next-state logic: swap beats new grants in IDLE; every grant ends via IDLE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;
        bank_d  = bank_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = SWAP;
                end else if (|ch_busy) begin
                    state_d = GRANT;
                    grant_d = pick;
                    last_d  = IDX_W'(onehot2idx(16'(pick)));
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!busy_g || hold_max) begin
                    state_d = IDLE;
                    grant_d = '0;
                    // Only a channel that is still busy counts as stuck.
                    if (busy_g) tmo_d = tmo_q | grant_q;
                end else begin
                    hold_d = hold_q + 1'b1;  // below max here, so never wraps
                end
            end
            SWAP: begin
                bank_d  = ~bank_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; a burst in flight is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(CHANNELS - 1);
            hold_q  <= '0;
            bank_q  <= 1'b0;
            pend_q  <= 1'b0;
            late_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            late_q  <= late_d;
            tmo_q   <= tmo_d;
        end
    end

    // Buffer port mux: only the granted channel reaches the buffer; zero when idle.
    always_comb begin
        buf_wdata = '0;
        buf_waddr = '0;
        buf_raddr = '0;
        buf_wren  = 1'b0;
        buf_rden  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_q[i]) begin
                buf_wdata = ch_wdata[i*DATA_W +: DATA_W];
                buf_waddr = ch_waddr[i*ADDR_W +: ADDR_W];
                buf_raddr = ch_raddr[i*ADDR_W +: ADDR_W];
                buf_wren  = ch_wren[i];
                buf_rden  = ch_rden[i];
            end
        end
    end

    assign ch_grant  = grant_q;
    assign ch_rdata  = buf_rdata;
    assign bank_sel  = bank_q;
    assign swap_late = late_q;
    assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_grp_buf_arbiter.sv
// Self-checking bench for grp_buf_arbiter: behavioural model + directed vectors.
module tb_grp_buf_arbiter;

    localparam int N  = 5;
    localparam int DW = 12;
    localparam int AW = 10;
    localparam int HM = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    busy, wren, rden;
    logic [DW-1:0]   wd [N];
    logic [AW-1:0]   wa [N];
    logic [AW-1:0]   ra [N];
    logic            swap_req;
    logic [DW-1:0]   rdata;

    logic [N*DW-1:0] ch_wdata;
    logic [N*AW-1:0] ch_waddr, ch_raddr;

    logic [N-1:0]    ch_grant, tmo_err;
    logic [DW-1:0]   ch_rdata, buf_wdata;
    logic [AW-1:0]   buf_waddr, buf_raddr;
    logic            buf_wren, buf_rden, bank_sel, swap_late;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit seen155 = 0;
    int ord[$];

    always_comb begin
        ch_wdata = '0;
        ch_waddr = '0;
        ch_raddr = '0;
        for (int i = 0; i < N; i++) begin
            ch_wdata[i*DW +: DW] = wd[i];
            ch_waddr[i*AW +: AW] = wa[i];
            ch_raddr[i*AW +: AW] = ra[i];
        end
    end

    grp_buf_arbiter #(.CHANNELS(N), .DATA_W(DW), .ADDR_W(AW), .HOLD_MAX(HM)) dut (
        .clk(clk), .reset(reset), .ch_busy(busy), .ch_wdata(ch_wdata), .ch_waddr(ch_waddr),
        .ch_wren(wren), .ch_raddr(ch_raddr), .ch_rden(rden), .ch_grant(ch_grant),
        .ch_rdata(ch_rdata), .buf_wdata(buf_wdata), .buf_waddr(buf_waddr), .buf_wren(buf_wren),
        .buf_raddr(buf_raddr), .buf_rden(buf_rden), .buf_rdata(rdata), .swap_req(swap_req),
        .bank_sel(bank_sel), .swap_late(swap_late), .tmo_err(tmo_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_owner = -1;   // channel holding the buffer, -1 = none
    int          m_cnt   = 0;    // cycles the owner has held beyond the first
    int          m_last  = N-1;
    bit          m_swapping = 0;
    bit          m_pend = 0, m_bank = 0, m_late = 0;
    logic [N-1:0] m_tmo = '0;

    function automatic int m_pick();
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (busy[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (busy[(m_last + k) % N]) return (m_last + k) % N;
`endif
        return -1;
    endfunction

    initial begin
        bit pend0;
        int p;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_owner = -1; m_cnt = 0; m_last = N-1; m_swapping = 0;
                m_pend = 0; m_bank = 0; m_late = 0; m_tmo = '0;
            end else begin
                pend0 = m_pend;
                if (swap_req && pend0) m_late = 1;
                if (m_swapping) begin
                    m_bank = ~m_bank;
                    m_swapping = 0;
                    m_pend = 0;
                end else begin
                    if (m_owner >= 0) begin
                        if (!busy[m_owner] || m_cnt == HM-1) begin
                            if (busy[m_owner]) m_tmo[m_owner] = 1'b1;
                            m_owner = -1;
                        end else begin
                            m_cnt++;
                        end
                    end else if (pend0) begin
                        m_swapping = 1;
                    end else begin
                        p = m_pick();
                        if (p >= 0) begin
                            m_owner = p; m_last = p; m_cnt = 0;
                        end
                    end
                    m_pend = pend0 | swap_req;
                end
            end
        end
    end

    // Compare every cycle, mid-period.
    initial begin
        logic [N-1:0] eg;
        forever begin
            @(negedge clk);
            if (buf_waddr == 10'h155) seen155 = 1;
            if (chk_en) begin
                eg = '0;
                if (m_owner >= 0) eg[m_owner] = 1'b1;
                chk("grant", 32'(ch_grant), 32'(eg));
                chk("wdata", 32'(buf_wdata), (m_owner >= 0) ? 32'(wd[m_owner]) : 0);
                chk("waddr", 32'(buf_waddr), (m_owner >= 0) ? 32'(wa[m_owner]) : 0);
                chk("raddr", 32'(buf_raddr), (m_owner >= 0) ? 32'(ra[m_owner]) : 0);
                chk("wren",  32'(buf_wren),  (m_owner >= 0) ? 32'(wren[m_owner]) : 0);
                chk("rden",  32'(buf_rden),  (m_owner >= 0) ? 32'(rden[m_owner]) : 0);
                chk("rdata", 32'(ch_rdata),  32'(rdata));
                chk("bank",  32'(bank_sel),  32'(m_bank));
                chk("late",  32'(swap_late), 32'(m_late));
                chk("tmo",   32'(tmo_err),   32'(m_tmo));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_inputs();
        busy = '0; wren = '0; rden = '0; swap_req = 1'b0; rdata = '0;
        for (int i = 0; i < N; i++) begin
            wd[i] = '0; wa[i] = '0; ra[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_inputs();
        cyc(2);
        reset = 1'b0;
    endtask

    // Every channel re-requests; each drops busy after 4 granted cycles.
    task automatic run_auto(input int n);
        int gc[N];
        bit rl[N];
        logic [N-1:0] prev;
        prev = '0;
        for (int i = 0; i < N; i++) begin gc[i] = 0; rl[i] = 0; end
        repeat (n) begin
            cyc(1);
            for (int i = 0; i < N; i++) begin
                if (ch_grant[i]) begin
                    gc[i]++;
                    if (gc[i] == 4) begin busy[i] = 1'b0; gc[i] = 0; rl[i] = 1; end
                end else if (rl[i]) begin
                    busy[i] = 1'b1; rl[i] = 0;
                end
            end
            if (ch_grant != '0 && ch_grant != prev)
                for (int i = 0; i < N; i++) if (ch_grant[i]) ord.push_back(i);
            prev = ch_grant;
        end
    endtask

    initial begin
        int n;
        int exp_ord[6];
        logic [N-1:0] exp7[5];
`ifdef ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0, 0};
        exp7    = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
`else
        exp_ord = '{0, 1, 2, 3, 4, 0};
        exp7    = '{5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00010};
`endif
        clr_inputs();
        cyc(1);
        chk_en = 1;

        // reset state, with write enables and addresses toggling on every channel
        wren = '1; rden = '1;
        for (int i = 0; i < N; i++) begin wa[i] = AW'(i + 1); ra[i] = AW'(i + 9); end
        cyc(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_grant", 32'(ch_grant), 0);
        chk("rst_wren",  32'(buf_wren), 0);
        chk("rst_rden",  32'(buf_rden), 0);
        chk("rst_waddr", 32'(buf_waddr), 0);
        chk("rst_bank",  32'(bank_sel), 0);
        chk("rst_late",  32'(swap_late), 0);
        chk("rst_tmo",   32'(tmo_err), 0);

        // 1) single requester ch2 for 10 cycles
        do_reset();
        busy = 5'b00100; wren[2] = 1'b1; wa[2] = 10'h0AB;
        cyc(1);
        @(negedge clk);
        chk("t1_grant_first", 32'(ch_grant), 4);
        chk("t1_waddr", 32'(buf_waddr), 'h0AB);
        cyc(9);
        @(negedge clk);
        chk("t1_grant_last", 32'(ch_grant), 4);
        busy = '0;
        cyc(1);
        @(negedge clk);
        chk("t1_grant_off", 32'(ch_grant), 0);

        // 2) all channels requesting
        do_reset();
        ord.delete();
        busy = '1;
        run_auto(40);
        chk("t2_ngrants", 32'(ord.size() >= 6), 1);
        for (int k = 0; k < 6; k++)
            chk("t2_order", (k < ord.size()) ? 32'(ord[k]) : 32'hFFFF, 32'(exp_ord[k]));

        // 3) ch1 stuck busy, ch2 waiting
        do_reset();
        busy = 5'b00110;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (ch_grant == 5'b00010) n++;
        end
        chk("t3_hold_cycles", 32'(n), 16);
        chk("t3_tmo", 32'(tmo_err), 'b00010);
        chk("t3_next_grant", 32'(ch_grant), 'b00100);
        busy = '0;
        cyc(3);

        // 4) swap request in the middle of a ch3 burst
        do_reset();
        busy = 5'b01000;
        cyc(3);
        swap_req = 1'b1;
        cyc(1);
        swap_req = 1'b0;
        cyc(4);
        @(negedge clk);
        chk("t4_bank_mid", 32'(bank_sel), 0);
        chk("t4_grant_mid", 32'(ch_grant), 'b01000);
        busy = '0;
        cyc(2);
        @(negedge clk);
        chk("t4_bank_preswap", 32'(bank_sel), 0);
        cyc(1);
        @(negedge clk);
        chk("t4_bank_swapped", 32'(bank_sel), 1);
        busy = 5'b00001;
        cyc(1);
        @(negedge clk);
        chk("t4_next_grant", 32'(ch_grant), 1);
        chk("t4_next_bank", 32'(bank_sel), 1);
        busy = '0;
        cyc(2);

        // 5) two swap requests during one burst
        do_reset();
        busy = 5'b00100;
        cyc(2); swap_req = 1'b1;
        cyc(1); swap_req = 1'b0;
        cyc(2); swap_req = 1'b1;
        cyc(1); swap_req = 1'b0;
        cyc(2); busy = '0;
        cyc(5);
        @(negedge clk);
        chk("t5_bank", 32'(bank_sel), 1);
        chk("t5_late", 32'(swap_late), 1);

        // 6) ch0 owns the buffer while ch2 drives wren with addr 0x155
        do_reset();
        seen155 = 0;
        busy = 5'b00101;
        wren[2] = 1'b1; rden[2] = 1'b1; wa[2] = 10'h155; ra[2] = 10'h155; wd[2] = 12'hFFF;
        wd[0] = 12'h123;
        for (int k = 0; k < 8; k++) begin
            wren[0] = k[0]; rden[0] = k[1];
            wa[0] = AW'(10'h020 + k); ra[0] = AW'(10'h100 + k); rdata = DW'(12'h800 + k);
            cyc(1);
        end
        wren[0] = 1'b0;
        @(negedge clk);
        chk("t6_wren_ch2_blocked", 32'(buf_wren), 0);
        wren[0] = 1'b1;
        #1;
        chk("t6_wren_ch0", 32'(buf_wren), 1);
        chk("t6_no_155", 32'(seen155), 0);
        busy = '0;
        cyc(3);

        // 7) repeated 10011 bursts
        do_reset();
        for (int r = 0; r < 5; r++) begin
            busy = 5'b10011;
            cyc(1);
            @(negedge clk);
            chk("t7_grant", 32'(ch_grant), 32'(exp7[r]));
            busy = '0;
            cyc(2);
        end

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
